// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Holds the bubble instruction, jump codes and fetch FSM states.
package if_pkg;

    // sll $0,$0,0: the canonical MIPS bubble
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    // EM_jump encodings; code 3 is reserved and behaves like JMP_NONE
    localparam logic [1:0] JMP_NONE = 2'd0;
    localparam logic [1:0] JMP_J    = 2'd1;
    localparam logic [1:0] JMP_JR   = 2'd2;

    // Fetch FSM, used only when multicycle instruction memory is enabled
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_next_pc.sv
// Next-PC logic: redirect detection, target select, word alignment and PC+4.
// Kept separate so that later branch-prediction work can reuse it.
module if_next_pc
    import if_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        pcsrc_i,
    input  logic [31:0] branch_target_i,
    input  logic [1:0]  jump_i,
    input  logic [31:0] jump_target_i,
    output logic        redirect_o,
    output logic [31:0] target_o,
    output logic [31:0] pc_plus4_o
);

    // Branch beats jump; the selected target is forced to a word boundary
    always_comb begin
        redirect_o = pcsrc_i || (jump_i == JMP_J) || (jump_i == JMP_JR);
        target_o   = pcsrc_i ? branch_target_i : jump_target_i;
        target_o[1:0] = 2'b00;
        // 32-bit modulo add: 0xFFFF_FFFC wraps to 0
        pc_plus4_o = pc_i + 32'd4;
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction-memory reads and
// holds the IF/ID pipeline register.
// Define IF_IMEM_WAIT_EN to enable the FETCH/WAIT/DROP FSM that honours
// imem_rdy; otherwise memory is treated as zero-wait and imem_rdy is ignored.
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        EM_PCSrc,
    input  logic [31:0] EM_BranchTarget,
    input  logic [1:0]  EM_jump,
    input  logic [31:0] EM_JumpTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rdy,
    output logic [31:0] IF_Instr,
    output logic [31:0] IF_PCPlus4,
    output logic        IF_Valid,
    output logic [31:0] pc
);

    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] pcp4_q;
    logic        valid_q;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        capture;

    if_next_pc u_next_pc (
        .pc_i            (pc_q),
        .pcsrc_i         (EM_PCSrc),
        .branch_target_i (EM_BranchTarget),
        .jump_i          (EM_jump),
        .jump_target_i   (EM_JumpTarget),
        .redirect_o      (redirect),
        .target_o        (target),
        .pc_plus4_o      (pc_plus4)
    );

`ifdef IF_IMEM_WAIT_EN
    fetch_state_e state_q;

    // Request/capture qualification from the fetch state
    always_comb begin
        capture  = (state_q != DROP) && !stall && imem_rdy;
        imem_req = rst_n && ((state_q == WAIT) || ((state_q == FETCH) && !stall));
    end

    // Fetch FSM: a request left pending by a redirect must be drained in DROP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (!stall && !imem_rdy)
                        state_q <= redirect ? DROP : WAIT;
                end
                WAIT: begin
                    if (redirect)
                        state_q <= imem_rdy ? FETCH : DROP;
                    else if (!stall && imem_rdy)
                        state_q <= FETCH;
                end
                DROP: begin
                    if (!redirect && !stall && imem_rdy)
                        state_q <= FETCH;
                end
                default: state_q <= FETCH;
            endcase
        end
    end
`else
    logic unused_imem_rdy;
    assign unused_imem_rdy = imem_rdy;

    // Zero-wait memory: every unstalled cycle completes a fetch
    always_comb begin
        capture  = !stall;
        imem_req = rst_n && !stall;
    end
`endif

    // PC and IF/ID register: redirect > stall > normal advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pcp4_q  <= '0;
            valid_q <= 1'b0;
        end else if (redirect) begin
            pc_q    <= target;
            instr_q <= NOP_INSTR;
            pcp4_q  <= '0;
            valid_q <= 1'b0;
        end else if (capture) begin
            pc_q    <= pc_plus4;
            instr_q <= imem_rdata;
            pcp4_q  <= pc_plus4;
            valid_q <= 1'b1;
        end
    end

    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign IF_Instr   = instr_q;
    assign IF_PCPlus4 = pcp4_q;
    assign IF_Valid   = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage. The memory model returns a
// fixed function of the address; expected values are hand-derived.
// Wait-state checks are compiled in when IF_IMEM_WAIT_EN is defined.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        EM_PCSrc;
    logic [31:0] EM_BranchTarget;
    logic [1:0]  EM_jump;
    logic [31:0] EM_JumpTarget;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rdy;
    logic [31:0] IF_Instr;
    logic [31:0] IF_PCPlus4;
    logic        IF_Valid;
    logic [31:0] pc;

    int n_assert = 0;
    int n_fail   = 0;

    if_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .EM_PCSrc        (EM_PCSrc),
        .EM_BranchTarget (EM_BranchTarget),
        .EM_jump         (EM_jump),
        .EM_JumpTarget   (EM_JumpTarget),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .imem_rdy        (imem_rdy),
        .IF_Instr        (IF_Instr),
        .IF_PCPlus4      (IF_PCPlus4),
        .IF_Valid        (IF_Valid),
        .pc              (pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        return a ^ 32'h2400_0000;
    endfunction

    assign imem_rdata = instr_at(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        EM_PCSrc = 1'b0;
        EM_BranchTarget = '0;
        EM_jump = 2'd0;
        EM_JumpTarget = '0;
        imem_rdy = 1'b1;

        #2;
        check("rst_pc", pc, 32'h0);
        check("rst_instr", IF_Instr, 32'h0);
        check("rst_pcp4", IF_PCPlus4, 32'h0);
        check("rst_valid", {31'b0, IF_Valid}, 32'd0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        tick();
        tick();
        check("rst_hold_req", {31'b0, imem_req}, 32'd0);

        // Reset release: sequential fetch from 0
        rst_n = 1'b1;
        #1;
        check("first_req", {31'b0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0);
        tick();
        check("seq0_pcp4", IF_PCPlus4, 32'h4);
        check("seq0_instr", IF_Instr, 32'h2400_0000);
        check("seq0_valid", {31'b0, IF_Valid}, 32'd1);
        check("seq1_addr", imem_addr, 32'h4);
        tick();
        check("seq1_pcp4", IF_PCPlus4, 32'h8);
        check("seq2_addr", imem_addr, 32'h8);
        tick();
        check("seq2_pcp4", IF_PCPlus4, 32'hC);
        check("seq3_pc", pc, 32'hC);

        // Taken branch, with a simultaneous jump that must lose
        EM_PCSrc = 1'b1;
        EM_BranchTarget = 32'h100;
        EM_jump = 2'd1;
        EM_JumpTarget = 32'h200;
        tick();
        check("br_pc", pc, 32'h100);
        check("br_valid", {31'b0, IF_Valid}, 32'd0);
        check("br_instr", IF_Instr, 32'h0);
        check("br_pcp4", IF_PCPlus4, 32'h0);
        EM_PCSrc = 1'b0;
        EM_jump = 2'd0;
        tick();
        check("br_tgt_pcp4", IF_PCPlus4, 32'h104);
        check("br_tgt_instr", IF_Instr, 32'h2400_0100);
        check("br_tgt_valid", {31'b0, IF_Valid}, 32'd1);

        // Jump to a misaligned target: low bits cleared
        EM_jump = 2'd1;
        EM_JumpTarget = 32'h1F;
        tick();
        check("j_align_pc", pc, 32'h1C);
        EM_jump = 2'd0;
        tick();
        check("pre_stall_pc", pc, 32'h20);
        check("pre_stall_instr", IF_Instr, 32'h2400_001C);

        // Stall three cycles at pc 0x20
        stall = 1'b1;
        #1;
        check("stall_req", {31'b0, imem_req}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", pc, 32'h20);
            check("stall_instr", IF_Instr, 32'h2400_001C);
            check("stall_valid", {31'b0, IF_Valid}, 32'd1);
        end

        // jr during stall still redirects
        EM_jump = 2'd2;
        EM_JumpTarget = 32'h40;
        tick();
        check("jr_stall_pc", pc, 32'h40);
        check("jr_stall_valid", {31'b0, IF_Valid}, 32'd0);
        stall = 1'b0;

        // Reserved jump code behaves as no jump
        EM_jump = 2'd3;
        EM_JumpTarget = 32'h300;
        tick();
        check("rsv_pc", pc, 32'h44);
        check("rsv_pcp4", IF_PCPlus4, 32'h44);
        check("rsv_instr", IF_Instr, 32'h2400_0040);
        EM_jump = 2'd0;

        // Wrap-around at the top of the address space
        EM_jump = 2'd1;
        EM_JumpTarget = 32'hFFFF_FFFC;
        tick();
        check("wrap_pre_pc", pc, 32'hFFFF_FFFC);
        EM_jump = 2'd0;
        #1;
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_pcp4", IF_PCPlus4, 32'h0);
        check("wrap_pc", pc, 32'h0);
        check("wrap_instr", IF_Instr, 32'hDBFF_FFFC);
        tick();
        check("post_wrap_pc", pc, 32'h4);

        // Asynchronous reset in mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_valid", {31'b0, IF_Valid}, 32'd0);
        check("mid_rst_pcp4", IF_PCPlus4, 32'h0);
        check("mid_rst_req", {31'b0, imem_req}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("rerel_addr", imem_addr, 32'h0);
        check("rerel_req", {31'b0, imem_req}, 32'd1);

`ifdef IF_IMEM_WAIT_EN
        // Two wait cycles: address held, data captured on the third
        imem_rdy = 1'b0;
        tick();
        check("w1_pc", pc, 32'h0);
        check("w1_valid", {31'b0, IF_Valid}, 32'd0);
        check("w1_req", {31'b0, imem_req}, 32'd1);
        check("w1_addr", imem_addr, 32'h0);
        tick();
        check("w2_req", {31'b0, imem_req}, 32'd1);
        check("w2_addr", imem_addr, 32'h0);
        imem_rdy = 1'b1;
        tick();
        check("w3_pcp4", IF_PCPlus4, 32'h4);
        check("w3_valid", {31'b0, IF_Valid}, 32'd1);
        check("w3_pc", pc, 32'h4);

        // Redirect while waiting: late data must be dropped
        imem_rdy = 1'b0;
        tick();
        EM_PCSrc = 1'b1;
        EM_BranchTarget = 32'h80;
        tick();
        check("drop_pc", pc, 32'h80);
        check("drop_valid", {31'b0, IF_Valid}, 32'd0);
        EM_PCSrc = 1'b0;
        #1;
        check("drop_req", {31'b0, imem_req}, 32'd0);
        imem_rdy = 1'b1;
        tick();
        check("late_valid", {31'b0, IF_Valid}, 32'd0);
        check("late_pc", pc, 32'h80);
        check("late_req", {31'b0, imem_req}, 32'd1);
        check("late_addr", imem_addr, 32'h80);
        tick();
        check("tgt80_pcp4", IF_PCPlus4, 32'h84);
        check("tgt80_instr", IF_Instr, 32'h2400_0080);
        check("tgt80_valid", {31'b0, IF_Valid}, 32'd1);
`else
        // Without wait states imem_rdy is ignored
        imem_rdy = 1'b0;
        tick();
        check("nordy_pcp4", IF_PCPlus4, 32'h4);
        check("nordy_valid", {31'b0, IF_Valid}, 32'd1);
        check("nordy_pc", pc, 32'h4);
        imem_rdy = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
